// File: rtl/axi_mem_resp_pkg.sv
// Shared types for the AXI4 memory responder.
// Queue entries carry max-width fields; the top casts to its parameters.
package axi_mem_resp_pkg;

  localparam int ID_MAX_W   = 8;
  localparam int IDX_MAX_W  = 32;
  localparam int DEF_DATA_W = 512;
  localparam int DEF_OFF_W  = $clog2(DEF_DATA_W / 8);

  typedef struct packed {
    logic [ID_MAX_W-1:0]  id;
    logic [IDX_MAX_W-1:0] index;
    logic [7:0]           len;
  } ar_entry_t;

  typedef struct packed {
    logic [IDX_MAX_W-1:0] index;
    logic [7:0]           len;
  } aw_entry_t;

  typedef enum logic {
    RD_IDLE,
    RD_BURST
  } rd_state_e;

  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_mem_resp_fifo.sv
// Small synchronous FIFO used for the AR and AW queues.
// Head entry is visible on dout whenever empty is low.
module axi_mem_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: INCR bursts served from a byte-strobed word array.
// Define AXI_MEM_RESP_STALL_EN for LFSR-driven random backpressure.
module axi_mem_responder
  import axi_mem_resp_pkg::*;
#(
  parameter int C_ID_WIDTH       = 1,
  parameter int C_ADDR_WIDTH     = 64,
  parameter int C_DATA_WIDTH     = DEF_DATA_W,
  parameter int C_MEM_DEPTH      = 4096,
  parameter int C_RD_OUTSTANDING = 4,
  parameter int C_WR_OUTSTANDING = 32
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [C_ID_WIDTH-1:0]     s_axi_arid,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                      s_axi_rlast,
  output logic [C_ID_WIDTH-1:0]     s_axi_rid
);

  localparam int OFF_W = byte_off_w(C_DATA_WIDTH);
  localparam int IDX_W = $clog2(C_MEM_DEPTH);
  localparam int BW    = C_DATA_WIDTH / 8;
  localparam int BC_W  = $clog2(C_WR_OUTSTANDING + 1);
  localparam logic [IDX_MAX_W-1:0] IDX_MASK =
    IDX_MAX_W'(C_MEM_DEPTH - 1);

  logic [C_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  function automatic logic [IDX_MAX_W-1:0] addr2idx(
    input logic [C_ADDR_WIDTH-1:0] a
  );
    return IDX_MAX_W'(a >> OFF_W) & IDX_MASK;
  endfunction

  function automatic ar_entry_t step(input ar_entry_t e);
    ar_entry_t n;
    n.id    = e.id;
    n.index = (e.index + IDX_MAX_W'(1)) & IDX_MASK;
    n.len   = e.len - 8'd1;
    return n;
  endfunction

  logic rdy_q;
  logic gate_a;
  logic gate_r;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) rdy_q <= 1'b0;
    else           rdy_q <= 1'b1;
  end

`ifdef AXI_MEM_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0],
                  lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign gate_a = lfsr[0];
  assign gate_r = lfsr[1];
`else
  assign gate_a = 1'b0;
  assign gate_r = 1'b0;
`endif

  // ---------------- read path ----------------
  ar_entry_t ar_in;
  ar_entry_t ar_head;
  logic      ar_push;
  logic      ar_pop;
  logic      ar_full;
  logic      ar_empty;

  assign s_axi_arready = rdy_q && !ar_full && !gate_a;
  assign ar_push       = s_axi_arvalid && s_axi_arready;
  assign ar_in.id      = ID_MAX_W'(s_axi_arid);
  assign ar_in.index   = addr2idx(s_axi_araddr);
  assign ar_in.len     = s_axi_arlen;

  axi_mem_resp_fifo #(
    .W     ($bits(ar_entry_t)),
    .DEPTH (C_RD_OUTSTANDING)
  ) u_ar_q (
    .clk   (aclk),
    .rst_n (areset_n),
    .push  (ar_push),
    .din   (ar_in),
    .pop   (ar_pop),
    .dout  (ar_head),
    .full  (ar_full),
    .empty (ar_empty)
  );

  rd_state_e rd_state;
  rd_state_e rd_next;
  ar_entry_t cur;
  ar_entry_t cur_next;
  ar_entry_t src;
  logic      issue;
  logic      r_space;
  logic      r_pop;
  logic [1:0] r_cnt;

  logic [C_DATA_WIDTH-1:0] r0_data;
  logic [C_DATA_WIDTH-1:0] r1_data;
  logic                    r0_last;
  logic                    r1_last;
  logic [C_ID_WIDTH-1:0]   r0_id;
  logic [C_ID_WIDTH-1:0]   r1_id;
  logic [C_DATA_WIDTH-1:0] n_data;
  logic                    n_last;
  logic [C_ID_WIDTH-1:0]   n_id;

  assign s_axi_rvalid = (r_cnt != 2'd0);
  assign s_axi_rdata  = r0_data;
  assign s_axi_rlast  = s_axi_rvalid && r0_last;
  assign s_axi_rid    = r0_id;
  assign r_pop        = s_axi_rvalid && s_axi_rready;
  assign r_space      = (r_cnt != 2'd2 || r_pop) && !gate_r;

  assign n_data = mem[IDX_W'(src.index)];
  assign n_last = (src.len == 8'd0);
  assign n_id   = C_ID_WIDTH'(src.id);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rd_state <= RD_IDLE;
      cur      <= '0;
    end else begin
      rd_state <= rd_next;
      cur      <= cur_next;
    end
  end

  always_comb begin
    rd_next  = rd_state;
    cur_next = cur;
    src      = cur;
    issue    = 1'b0;
    ar_pop   = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        if (!ar_empty && r_space) begin
          ar_pop = 1'b1;
          issue  = 1'b1;
          src    = ar_head;
          if (ar_head.len != 8'd0) begin
            rd_next  = RD_BURST;
            cur_next = step(ar_head);
          end
        end
      end
      RD_BURST: begin
        if (r_space) begin
          issue = 1'b1;
          if (cur.len != 8'd0) begin
            cur_next = step(cur);
          end else if (!ar_empty) begin
            ar_pop   = 1'b1;
            cur_next = ar_head;
          end else begin
            rd_next = RD_IDLE;
          end
        end
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  // r0 is the visible beat, r1 the skid slot
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt   <= 2'd0;
      r0_data <= '0;
      r1_data <= '0;
      r0_last <= 1'b0;
      r1_last <= 1'b0;
      r0_id   <= '0;
      r1_id   <= '0;
    end else begin
      case ({issue, r_pop})
        2'b10: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd0) begin
            r0_data <= n_data;
            r0_last <= n_last;
            r0_id   <= n_id;
          end else begin
            r1_data <= n_data;
            r1_last <= n_last;
            r1_id   <= n_id;
          end
        end
        2'b01: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd2) begin
            r0_data <= r1_data;
            r0_last <= r1_last;
            r0_id   <= r1_id;
          end
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r0_data <= n_data;
            r0_last <= n_last;
            r0_id   <= n_id;
          end else begin
            r0_data <= r1_data;
            r0_last <= r1_last;
            r0_id   <= r1_id;
            r1_data <= n_data;
            r1_last <= n_last;
            r1_id   <= n_id;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- write path ----------------
  aw_entry_t aw_in;
  aw_entry_t aw_head;
  logic      aw_push;
  logic      aw_full;
  logic      aw_empty;
  logic      w_hs;
  logic      w_end;
  logic      b_hs;
  logic      wlast_err;
  logic [7:0] w_off;
  logic [IDX_MAX_W-1:0] w_idx;
  logic [BC_W-1:0] b_pend;

  assign s_axi_awready = rdy_q && !aw_full && !gate_a;
  assign aw_push       = s_axi_awvalid && s_axi_awready;
  assign aw_in.index   = addr2idx(s_axi_awaddr);
  assign aw_in.len     = s_axi_awlen;

  axi_mem_resp_fifo #(
    .W     ($bits(aw_entry_t)),
    .DEPTH (C_WR_OUTSTANDING)
  ) u_aw_q (
    .clk   (aclk),
    .rst_n (areset_n),
    .push  (aw_push),
    .din   (aw_in),
    .pop   (w_end),
    .dout  (aw_head),
    .full  (aw_full),
    .empty (aw_empty)
  );

  assign s_axi_wready = rdy_q && !aw_empty && !gate_a &&
                        (b_pend < BC_W'(C_WR_OUTSTANDING));
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign w_end = w_hs && (s_axi_wlast || w_off == aw_head.len);
  assign w_idx = (aw_head.index + IDX_MAX_W'(w_off)) & IDX_MASK;

  assign s_axi_bvalid = (b_pend != '0);
  assign b_hs         = s_axi_bvalid && s_axi_bready;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_off     <= 8'd0;
      wlast_err <= 1'b0;
      b_pend    <= '0;
    end else begin
      if (w_hs) w_off <= w_end ? 8'd0 : w_off + 8'd1;
      // wlast must coincide with beat len+1; either mismatch ends the burst
      if (w_end && (s_axi_wlast != (w_off == aw_head.len)))
        wlast_err <= 1'b1;
      b_pend <= b_pend + BC_W'(w_end) - BC_W'(b_hs);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int b = 0; b < BW; b++) begin
        if (s_axi_wstrb[b])
          mem[IDX_W'(w_idx)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  logic sink_unused;
  assign sink_unused = ^{s_axi_arsize, wlast_err};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_axi_mem_responder;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int DEPTH = 4096;

  logic          clk;
  logic          areset_n;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast;
  logic          bvalid;
  logic          bready;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [0:0]    arid;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic [0:0]    rid;

  int checks;
  int errors;

  logic [DW-1:0] rd_data [256];
  logic          rd_last [256];
  logic [0:0]    rd_id   [256];
  int            rd_n;
  int            rd_first;

  axi_mem_responder dut (
    .aclk          (clk),
    .areset_n      (areset_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arid    (arid),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rlast   (rlast),
    .s_axi_rid     (rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_write(
    input  logic [AW-1:0]   addr,
    input  logic [7:0]      len,
    input  int              nb,
    input  logic [DW/8-1:0] strb,
    input  logic [DW-1:0]   base,
    input  logic [DW-1:0]   inc,
    output logic            bv_pre,
    output logic            bv_post
  );
    int t;
    bv_pre = 1'bx;
    @(negedge clk);
    awvalid = 1'b1;
    awaddr  = addr;
    awlen   = len;
    t = 0;
    while (!awready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1;
      wdata  = base + inc * DW'(i);
      wstrb  = strb;
      wlast  = (i == nb - 1);
      t = 0;
      while (!wready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (i == nb - 1) bv_pre = bvalid;
      @(negedge clk);
    end
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bv_post = bvalid;
    bready  = 1'b1;
    @(negedge clk);
    bready  = 1'b0;
  endtask

  task automatic do_read(
    input logic [AW-1:0] addr,
    input logic [7:0]    len,
    input logic [0:0]    id,
    input bit            toggle
  );
    int t;
    int cyc;
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = addr;
    arlen   = len;
    arid    = id;
    t = 0;
    while (!arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    arvalid  = 1'b0;
    cyc      = 1;
    rd_n     = 0;
    rd_first = -1;
    while (rd_n <= int'(len) && cyc < 300) begin
      rready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (rvalid && rd_first < 0) rd_first = cyc;
      if (rvalid && rready && rd_n < 256) begin
        rd_data[rd_n] = rdata;
        rd_last[rd_n] = rlast;
        rd_id[rd_n]   = rid;
        rd_n++;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({arready, awready, wready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready got %b want 000",
               {arready, awready, wready});
    end
    checks++;
    if ({bvalid, rvalid, rlast, rid} !== 4'b0000 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_out got b%b r%b l%b id%b",
               bvalid, rvalid, rlast, rid);
    end
    areset_n = 1'b1;
    checks++;
    if (arready !== 1'b0) begin
      errors++;
      $display("FAIL release_same got %b want 0", arready);
    end
    @(negedge clk);
    checks++;
    if ({arready, awready, wready} !== 3'b110) begin
      errors++;
      $display("FAIL release_ready got %b want 110",
               {arready, awready, wready});
    end
  endtask

  task automatic test_single_read;
    logic bp;
    logic ba;
    int t;
    do_write(64'h0, 8'd3, 4, '1, DW'(8'hA0), DW'(1), bp, ba);
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = 64'h0;
    arlen   = 8'd3;
    arid    = 1'b1;
    rready  = 1'b1;
    t = 0;
    while (!arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_lat_c1 rvalid got %b want 0", rvalid);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== DW'(8'hA0 + i) ||
          rlast !== (i == 3) || rid !== 1'b1) begin
        errors++;
        $display("FAIL single_beat%0d got v%b d%0h l%b id%b want d%0h",
                 i, rvalid, rdata[31:0], rlast, rid, 8'hA0 + i);
      end
      @(negedge clk);
    end
    rready = 1'b0;
  endtask

  task automatic test_write_read;
    logic bp;
    logic ba;
    do_write(64'h400, 8'd15, 16, '1, '0, DW'(1), bp, ba);
    checks++;
    if (bp !== 1'b0 || ba !== 1'b1) begin
      errors++;
      $display("FAIL wr_bvalid got pre%b post%b want 0 1", bp, ba);
    end
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_drain bvalid got %b want 0", bvalid);
    end
    do_read(64'h400, 8'd15, 1'b0, 1'b0);
    checks++;
    if (rd_n != 16 || rd_first != 2) begin
      errors++;
      $display("FAIL wr_rd_cnt got n%0d lat%0d want 16 2",
               rd_n, rd_first);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data[i] !== DW'(i) || rd_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL wr_rd_beat%0d got %0h l%b want %0h",
                 i, rd_data[i][31:0], rd_last[i], i);
      end
    end
  endtask

  task automatic test_partial_strobe;
    logic bp;
    logic ba;
    logic [DW-1:0] exp;
    exp = {{(DW-32){1'b1}}, 32'h0};
    do_write(64'h140, 8'd0, 1, '1, '1, '0, bp, ba);
    do_write(64'h140, 8'd0, 1, 64'h0F, '0, '0, bp, ba);
    do_read(64'h140, 8'd0, 1'b0, 1'b0);
    checks++;
    if (rd_n != 1 || rd_data[0] !== exp || rd_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL partial got n%0d low%0h hi%0h",
               rd_n, rd_data[0][63:0], rd_data[0][DW-1:DW-32]);
    end
  endtask

  task automatic test_early_wlast;
    logic bp;
    logic ba;
    do_write(64'hA00, 8'd3, 2, '1, DW'(8'h55), DW'(8'h11), bp, ba);
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL early_wlast bvalid got %b want 1", ba);
    end
    do_write(64'hA80, 8'd0, 1, '1, DW'(8'h77), '0, bp, ba);
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL after_early bvalid got %b want 1", ba);
    end
    do_read(64'hA00, 8'd2, 1'b1, 1'b0);
    checks++;
    if (rd_n != 3 || rd_data[0] !== DW'(8'h55) ||
        rd_data[1] !== DW'(8'h66) || rd_data[2] !== DW'(8'h77)) begin
      errors++;
      $display("FAIL early_data got n%0d %0h %0h %0h want 55 66 77",
               rd_n, rd_data[0][7:0], rd_data[1][7:0], rd_data[2][7:0]);
    end
  endtask

  task automatic test_backpressure;
    int t;
    int cyc;
    bit rose;
    int exp;
    rready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      arvalid = 1'b1;
      araddr  = (k < 4) ? AW'(64'h400 + k * 256) : 64'h400;
      arlen   = 8'd3;
      arid    = 1'(k % 2);
      t = 0;
      while (!arready && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
    end
    arvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (arready !== 1'b0) begin
        errors++;
        $display("FAIL ar_full c%0d arready got %b want 0", c, arready);
      end
      @(negedge clk);
    end
    rd_n = 0;
    cyc  = 0;
    rose = 1'b0;
    while (rd_n < 20 && cyc < 300) begin
      rready = (cyc % 2 == 0);
      if (arready) rose = 1'b1;
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata;
        rd_last[rd_n] = rlast;
        rd_id[rd_n]   = rid;
        rd_n++;
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    checks++;
    if (rd_n != 20 || !rose) begin
      errors++;
      $display("FAIL bp_count got n%0d rose%b want 20 1", rd_n, rose);
    end
    for (int i = 0; i < 20; i++) begin
      exp = (i < 16) ? i : i - 16;
      checks++;
      if (rd_data[i] !== DW'(exp) || rd_last[i] !== (i % 4 == 3) ||
          rd_id[i] !== 1'((i / 4) % 2)) begin
        errors++;
        $display("FAIL bp_beat%0d got %0h l%b id%b want %0h",
                 i, rd_data[i][31:0], rd_last[i], rd_id[i], exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int t;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      arvalid = 1'b1;
      araddr  = (k == 0) ? 64'h400 : 64'h500;
      arlen   = 8'd3;
      arid    = 1'(k);
      t = 0;
      while (!arready && t < 50) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    t = 0;
    while (!rvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== DW'(i) ||
          rid !== 1'(i / 4)) begin
        errors++;
        $display("FAIL b2b_beat%0d got v%b d%0h id%b want %0h",
                 i, rvalid, rdata[31:0], rid, i);
      end
      @(negedge clk);
    end
    rready = 1'b0;
  endtask

  task automatic test_wrap_reset;
    logic bp;
    logic ba;
    int t;
    do_write(AW'((DEPTH - 2) * 64), 8'd3, 4, '1,
             DW'(8'hB0), DW'(1), bp, ba);
    do_read(AW'((DEPTH - 2) * 64), 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== DW'(8'hB0 + i)) begin
        errors++;
        $display("FAIL wrap_beat%0d got %0h want %0h",
                 i, rd_data[i][7:0], 8'hB0 + i);
      end
    end
    do_read(64'h40, 8'd0, 1'b0, 1'b0);
    checks++;
    if (rd_data[0] !== DW'(8'hB3)) begin
      errors++;
      $display("FAIL wrap_idx1 got %0h want b3", rd_data[0][7:0]);
    end
    @(negedge clk);
    arvalid = 1'b1;
    araddr  = 64'h400;
    arlen   = 8'd15;
    arid    = 1'b1;
    t = 0;
    while (!arready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_burst rvalid got %b want 1", rvalid);
    end
    areset_n = 1'b0;
    #1;
    checks++;
    if ({rvalid, rlast, arready, bvalid} !== 4'b0000 ||
        rdata !== '0 || rid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v%b l%b ar%b b%b",
               rvalid, rlast, arready, bvalid);
    end
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    do_read(64'h400, 8'd0, 1'b1, 1'b0);
    checks++;
    if (rd_n != 1 || rd_data[0] !== '0 || rd_id[0] !== 1'b1 ||
        rd_first != 2 || rd_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got n%0d d%0h id%b lat%0d",
               rd_n, rd_data[0][7:0], rd_id[0], rd_first);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    areset_n = 1'b0;
    awvalid  = 1'b0;
    awaddr   = '0;
    awlen    = '0;
    wvalid   = 1'b0;
    wdata    = '0;
    wstrb    = '0;
    wlast    = 1'b0;
    bready   = 1'b0;
    arvalid  = 1'b0;
    araddr   = '0;
    arlen    = '0;
    arsize   = 3'd6;
    arid     = '0;
    rready   = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_partial_strobe();
    test_early_wlast();
    test_backpressure();
    test_back_to_back();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
